// File: rtl/melody_recorder_if.sv
// rtl/melody_recorder_if.sv - control and voice bundle for the melody recorder
//
// Purpose: groups the record/play controls, the live key input and the four
// voice outputs with their status flags.
// Ports (signals):
//   rec, play, stop    control levels from the front panel
//   key[3:0]           currently pressed key code (0 = none, 1 = treated as none)
//   beats[7:0]         memory index of the note on out
//   out..out4[3:0]     voice 1 and its 1/2/3-beat delayed copies
//   recording, playing state flags
//   length[7:0]        number of recorded beats
// Modports: master drives controls and key, slave (the recorder) drives the rest.
interface melody_recorder_if;
  logic       rec;
  logic       play;
  logic       stop;
  logic [3:0] key;
  logic [7:0] beats;
  logic [3:0] out;
  logic [3:0] out2;
  logic [3:0] out3;
  logic [3:0] out4;
  logic       recording;
  logic       playing;
  logic [7:0] length;

  modport master (
    output rec, play, stop, key,
    input  beats, out, out2, out3, out4, recording, playing, length
  );

  modport slave (
    input  rec, play, stop, key,
    output beats, out, out2, out3, out4, recording, playing, length
  );
endinterface

// File: rtl/melody_recorder.sv
// rtl/melody_recorder.sv - records a key stream and plays it back as a four-voice round
//
// Purpose: samples the key once per beat into a note memory (0 rest, 1 sustain,
// 2..15 pitch), then replays it on out with out2..out4 as 1/2/3-beat delayed voices.
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   bus   melody_recorder_if.slave (controls, key, voices, status)
// Parameters:
//   BEAT_DIV  clk cycles per beat (>= 2)
//   DEPTH     note memory entries, maximum recording length (<= 255)
module melody_recorder #(
  parameter int BEAT_DIV = 12500000,
  parameter int DEPTH    = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  melody_recorder_if.slave         bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(BEAT_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(BEAT_DIV - 1);
  localparam logic [7:0]    DEPTH_LAST = 8'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [7:0]    r_addr;
  logic [7:0]    r_len;
  logic [3:0]    r_prev;
  logic [7:0]    r_rd;
  logic [7:0]    r_beats;
  logic [1:0]    r_drain;
  logic [3:0]    r_out;
  logic [3:0]    r_out2;
  logic [3:0]    r_out3;
  logic [3:0]    r_out4;
  logic [3:0]    w_key;
  logic [3:0]    w_code;
  logic [3:0]    w_rd_data;
  logic [3:0]    r_mem [DEPTH];

  always_comb begin
    w_tick    = (r_state != S_IDLE) && (r_div == DIV_LAST);
    // Code 1 means "sustain" in memory, so a raw key of 1 is folded to a rest.
    w_key     = (bus.key == 4'd1) ? 4'd0 : bus.key;
    w_code    = (w_key == 4'd0) ? 4'd0 : (w_key == r_prev) ? 4'd1 : w_key;
    w_rd_data = r_mem[r_rd[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.rec)                       w_next = S_REC;
        else if (bus.play && r_len != 8'd0) w_next = S_PLAY;
      end
      S_REC: begin
        if ((w_tick && r_addr == DEPTH_LAST) || bus.stop) w_next = S_IDLE;
      end
      S_PLAY: begin
        if (bus.stop)                               w_next = S_IDLE;
        else if (w_tick && r_rd == r_len - 8'd1)    w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.stop)                       w_next = S_IDLE;
        else if (w_tick && r_drain == 2'd2) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Beat divider restarts on every state change so the first tick of any
  // phase lands exactly BEAT_DIV cycles after entry.
  always_ff @(posedge clk) begin
    if (!rst || r_state == S_IDLE || w_next != r_state || w_tick) r_div <= '0;
    else                                                          r_div <= r_div + 1'b1;
  end

  // Note memory survives reset on purpose.
  always_ff @(posedge clk) begin
    if (r_state == S_REC && w_tick) r_mem[r_addr[AW-1:0]] <= w_code;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr <= 8'd0;
      r_prev <= 4'd0;
      r_len  <= 8'd0;
    end else if (r_state == S_IDLE) begin
      if (w_next == S_REC) begin
        r_addr <= 8'd0;
        r_prev <= 4'd0;
      end
    end else if (r_state == S_REC) begin
      if (w_tick) begin
        r_addr <= r_addr + 8'd1;
        r_prev <= w_key;
      end
      // A tick coinciding with stop has already written, so it counts.
      if (w_next == S_IDLE) r_len <= w_tick ? r_addr + 8'd1 : r_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd    <= 8'd0;
      r_beats <= 8'd0;
      r_drain <= 2'd0;
      r_out   <= 4'd0;
      r_out2  <= 4'd0;
      r_out3  <= 4'd0;
      r_out4  <= 4'd0;
    end else if (r_state == S_IDLE) begin
      // Voices rest while idle; the tail shifted out on the final drain tick
      // is visible for one cycle before this clears it.
      r_out  <= 4'd0;
      r_out2 <= 4'd0;
      r_out3 <= 4'd0;
      r_out4 <= 4'd0;
      if (w_next == S_PLAY) begin
        r_rd    <= 8'd0;
        r_beats <= 8'd0;
        r_drain <= 2'd0;
      end
    end else if ((r_state == S_PLAY || r_state == S_DRAIN) && bus.stop) begin
      r_out  <= 4'd0;
      r_out2 <= 4'd0;
      r_out3 <= 4'd0;
      r_out4 <= 4'd0;
    end else if (r_state == S_PLAY && w_tick) begin
      r_out   <= w_rd_data;
      r_out2  <= r_out;
      r_out3  <= r_out2;
      r_out4  <= r_out3;
      r_beats <= r_rd;
      r_rd    <= r_rd + 8'd1;
    end else if (r_state == S_DRAIN && w_tick) begin
      r_out   <= 4'd0;
      r_out2  <= r_out;
      r_out3  <= r_out2;
      r_out4  <= r_out3;
      r_drain <= r_drain + 2'd1;
    end
  end

  assign bus.beats     = r_beats;
  assign bus.out       = r_out;
  assign bus.out2      = r_out2;
  assign bus.out3      = r_out3;
  assign bus.out4      = r_out4;
  assign bus.recording = (r_state == S_REC);
  assign bus.playing   = (r_state == S_PLAY) || (r_state == S_DRAIN);
  assign bus.length    = r_len;

endmodule
